// File: rtl/conv_pkg.sv
// Shared types for the convolution event path.
// Holds the event_writer FSM state encoding. Word packing is done locally in
// event_writer because the field widths are parameter-dependent.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVENT  = 2'd1,
      MARKER = 2'd2
   } ew_state_t;

endpackage

// File: rtl/fifo_if.sv
// Input event FIFO write-side interface.
// Ports (producer view): write_en (out), write_data (out, DATA_WIDTH), full (in).
interface fifo_if #(
   parameter int DATA_WIDTH = 15
) ();

   logic                  write_en;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  full;

   modport producer (output write_en, output write_data, input full);
   modport consumer (input write_en, input write_data, output full);

endinterface

// File: rtl/event_writer_sat_counter.sv
// Saturating up-counter, sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc (count enable), count (W bits).
module event_writer_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/event_writer.sv
// event_writer: packs spike events into event FIFO words {timestep, x, y, spikes}
// and inserts timestep marker words (timestep=1, rest 0) on request.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   event handshake; in_x, in_y, in_spikes event fields
//   timestep_req        one-cycle request for one marker
//   fifo_port           fifo_if producer: write_en, write_data, full
//   drop_count          saturating count of out-of-range events
//   ts_overflow         sticky, a marker request was lost
// Build option: EVENT_WRITER_ZERO_SKIP_EN discards in-range events whose
// spike vector is all zero (no write, no drop count).
//
// state  | meaning
// IDLE   | holding register empty, nothing to write
// EVENT  | holding register has an event word waiting for !full
// MARKER | holding register has a marker word; pending markers remain
module event_writer
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH           = 28,
   parameter int IMG_HEIGHT          = 28,
   parameter int BITS_PER_COORDINATE = 5,
   parameter int IN_CHANNELS         = 4,
   parameter int TS_PEND_W           = 2,
   parameter int DROP_CNT_W          = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [BITS_PER_COORDINATE-1:0] in_x,
   input  logic [BITS_PER_COORDINATE-1:0] in_y,
   input  logic [IN_CHANNELS-1:0]         in_spikes,
   input  logic                           timestep_req,
   fifo_if.producer                       fifo_port,
   output logic [DROP_CNT_W-1:0]          drop_count,
   output logic                           ts_overflow
);

   localparam int DATA_WIDTH = 1 + 2*BITS_PER_COORDINATE + IN_CHANNELS;
   localparam logic [BITS_PER_COORDINATE:0] X_LIM = IMG_WIDTH[BITS_PER_COORDINATE:0];
   localparam logic [BITS_PER_COORDINATE:0] Y_LIM = IMG_HEIGHT[BITS_PER_COORDINATE:0];
   localparam logic [TS_PEND_W-1:0]         PEND_MAX = '1;
   localparam logic [DATA_WIDTH-1:0]        MARKER_WORD = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   ew_state_t              state_q, state_d;
   logic [DATA_WIDTH-1:0]  hold_q, hold_d;
   logic [TS_PEND_W-1:0]   pend_q, pend_d;
   logic                   ovf_q;

   logic full;
   logic write_en;
   logic accept;
   logic in_range;
   logic skip;
   logic keep;
   logic drop;
   logic mark_wr;
   logic pend_inc;
   logic pend_lost;
   logic pick_next;
   logic [DATA_WIDTH-1:0] event_word;

   assign full     = fifo_port.full;
   assign write_en = (state_q != IDLE) && !full;
   assign in_ready = rst_n && (pend_q == '0) &&
                     ((state_q == IDLE) || ((state_q == EVENT) && !full));
   assign accept   = in_valid && in_ready;
   assign in_range = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);

`ifdef EVENT_WRITER_ZERO_SKIP_EN
   assign skip = (in_spikes == '0);
`else
   assign skip = 1'b0;
`endif

   assign keep       = accept && in_range && !skip;
   assign drop       = accept && !in_range;
   assign event_word = {1'b0, in_x, in_y, in_spikes};

   // A request at the ceiling survives only if a marker leaves the same cycle.
   assign mark_wr   = (state_q == MARKER) && write_en;
   assign pend_inc  = timestep_req && ((pend_q != PEND_MAX) || mark_wr);
   assign pend_lost = timestep_req && !pend_inc;

   always_comb begin
      pend_d = pend_q;
      case ({pend_inc, mark_wr})
         2'b10:   pend_d = pend_q + 1'b1;
         2'b01:   pend_d = pend_q - 1'b1;
         default: pend_d = pend_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      pick_next = 1'b0;
      case (state_q)
         IDLE:   pick_next = 1'b1;
         EVENT:  pick_next = !full;
         MARKER: begin
            if (!full) begin
               if (pend_d == '0) state_d = IDLE;
               else              hold_d  = MARKER_WORD;
            end
         end
         default: state_d = IDLE;
      endcase

      // An event taken alongside a request goes first; the marker follows it.
      if (pick_next) begin
         if (pend_q != '0) begin
            state_d = MARKER;
            hold_d  = MARKER_WORD;
         end else if (keep) begin
            state_d = EVENT;
            hold_d  = event_word;
         end else if (timestep_req) begin
            state_d = MARKER;
            hold_d  = MARKER_WORD;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_q | pend_lost;
      end
   end

   event_writer_sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop),
      .count (drop_count)
   );

   assign fifo_port.write_en   = write_en;
   assign fifo_port.write_data = hold_q;
   assign ts_overflow          = ovf_q;

endmodule

// File: tb/tb_event_writer.sv
module tb_event_writer;

   localparam int DW = 15;
   localparam int IW = 28;
   localparam int IH = 28;
   localparam logic [DW-1:0] MK = 15'h4000;
`ifdef EVENT_WRITER_ZERO_SKIP_EN
   localparam bit ZSKIP = 1'b1;
`else
   localparam bit ZSKIP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [4:0] in_x = '0;
   logic [4:0] in_y = '0;
   logic [3:0] in_spikes = '0;
   logic       timestep_req = 1'b0;
   logic       full = 1'b0;
   logic        in_ready;
   logic [15:0] drop_count;
   logic        ts_overflow;

   always #5 clk = ~clk;

   fifo_if #(.DATA_WIDTH(DW)) fif ();
   assign fif.full = full;

   event_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_spikes    (in_spikes),
      .timestep_req (timestep_req),
      .fifo_port    (fif),
      .drop_count   (drop_count),
      .ts_overflow  (ts_overflow)
   );

   // Reference model: queue of words owed to the FIFO, in order.
   logic [DW-1:0] q[$];
   int  m_drops = 0;
   bit  m_ovf = 0;
   int  tests = 0;
   int  fails = 0;
   int  wr_seen = 0;

   typedef struct {
      logic [4:0]    x;
      logic [4:0]    y;
      logic [3:0]    s;
      bit            wr;
      logic [DW-1:0] word;
      int            dinc;
   } vec_t;
   vec_t vecs[8];

   function automatic int nmark();
      int n = 0;
      foreach (q[i]) if (q[i][DW-1]) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are already driven; check at negedge, advance the model, step.
   task automatic cycle();
      bit exp_ready, exp_we, popped_mk;
      int m;
      @(negedge clk);
      exp_ready = (nmark() == 0) && ((q.size() == 0) || !full);
      exp_we    = (q.size() > 0) && !full;
      chk("in_ready", in_ready, exp_ready);
      chk("write_en", fif.write_en, exp_we);
      if (q.size() > 0) chk("write_data", fif.write_data, q[0]);
      chk("drop_count", drop_count, m_drops);
      chk("ts_overflow", ts_overflow, m_ovf);
      if (fif.write_en) wr_seen++;
      m = nmark();
      popped_mk = 1'b0;
      if (exp_we) begin
         popped_mk = q[0][DW-1];
         void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
         if (in_x >= IW || in_y >= IH) begin
            if (m_drops < 65535) m_drops++;
         end else if (!(ZSKIP && in_spikes == 4'd0)) begin
            q.push_back({1'b0, in_x, in_y, in_spikes});
         end
      end
      if (timestep_req) begin
         if (m == 3 && !popped_mk) m_ovf = 1'b1;
         else q.push_back(MK);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input string tag, input bit we, input logic [DW-1:0] d);
      #2;
      chk({tag, "_we"}, fif.write_en, we);
      if (we) chk({tag, "_data"}, fif.write_data, d);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      timestep_req = 1'b0;
   endtask

   initial begin
      vecs[0] = '{5'd3,  5'd7,  4'b1010, 1'b1, {1'b0, 5'd3,  5'd7,  4'b1010}, 0};
      vecs[1] = '{5'd27, 5'd27, 4'b1111, 1'b1, {1'b0, 5'd27, 5'd27, 4'b1111}, 0};
      vecs[2] = '{5'd28, 5'd5,  4'b0001, 1'b0, 15'h0, 1};
      vecs[3] = '{5'd4,  5'd28, 4'b0100, 1'b0, 15'h0, 1};
      vecs[4] = '{5'd31, 5'd31, 4'b1111, 1'b0, 15'h0, 1};
      vecs[5] = '{5'd0,  5'd0,  4'b0000, !ZSKIP, 15'h0000, 0};
      vecs[6] = '{5'd27, 5'd0,  4'b0001, 1'b1, {1'b0, 5'd27, 5'd0,  4'b0001}, 0};
      vecs[7] = '{5'd0,  5'd27, 4'b1000, 1'b1, {1'b0, 5'd0,  5'd27, 4'b1000}, 0};

      // Reset state.
      repeat (2) begin
         @(negedge clk);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_write_en", fif.write_en, 0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_data", fif.write_data, 0);
      cycle();

      // Table of single events.
      foreach (vecs[i]) begin
         in_valid = 1'b1;
         in_x = vecs[i].x; in_y = vecs[i].y; in_spikes = vecs[i].s;
         cycle();
         in_valid = 1'b0;
         peek($sformatf("vec%0d", i), vecs[i].wr, vecs[i].word);
         if (vecs[i].dinc != 0) chk($sformatf("vec%0d_ready", i), in_ready, 1);
         cycle();
      end

      // Event and timestep request in the same cycle.
      in_valid = 1'b1; in_x = 5'd1; in_y = 5'd1; in_spikes = 4'b0001; timestep_req = 1'b1;
      cycle();
      idle_inputs();
      peek("evts_ev", 1'b1, 15'b0_00001_00001_0001);
      chk("evts_ready_lo", in_ready, 0);
      cycle();
      peek("evts_mk", 1'b1, MK);
      chk("evts_ready_lo2", in_ready, 0);
      cycle();
      cycle();

      // Held event under 10 cycles of full.
      full = 1'b1;
      in_valid = 1'b1; in_x = 5'd5; in_y = 5'd9; in_spikes = 4'b0011;
      cycle();
      idle_inputs();
      wr_seen = 0;
      repeat (10) cycle();
      chk("stall_no_write", wr_seen, 0);
      full = 1'b0;
      repeat (3) cycle();
      chk("stall_one_write", wr_seen, 1);

      // Four requests while full overflow a 3-deep pending count.
      full = 1'b1;
      repeat (4) begin
         timestep_req = 1'b1;
         cycle();
      end
      timestep_req = 1'b0;
      cycle();
      chk("ovf_sticky", ts_overflow, 1);
      wr_seen = 0;
      full = 1'b0;
      repeat (6) cycle();
      chk("ovf_three_markers", wr_seen, 3);

      // Reset in the middle of a held word.
      full = 1'b1;
      in_valid = 1'b1; in_x = 5'd2; in_y = 5'd2; in_spikes = 4'b0110; timestep_req = 1'b1;
      cycle();
      idle_inputs();
      full = 1'b0;
      #1;
      chk("midrst_we_before", fif.write_en, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_we_drop", fif.write_en, 0);
      chk("midrst_ready", in_ready, 0);
      chk("midrst_ovf", ts_overflow, 0);
      q.delete();
      m_drops = 0;
      m_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (2) cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         in_valid     = 1'($urandom_range(0, 1));
         in_x         = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 27));
         in_y         = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 27));
         in_spikes    = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         timestep_req = ($urandom_range(0, 5) == 0);
         full         = ($urandom_range(0, 3) == 0);
         cycle();
      end
      idle_inputs();
      full = 1'b0;
      repeat (8) cycle();
      chk("drain_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
